// File: rtl/nibble_stream_pkg.sv
// Shared definitions for the nibble-stream stages: keep encodings, the
// downsizer state encoding and the keep-to-nibble-count decode.
package nibble_stream_pkg;

  localparam logic [7:0] KEEP_1NIB = 8'd4;
  localparam logic [7:0] KEEP_2NIB = 8'd8;
  localparam logic [7:0] KEEP_3NIB = 8'd12;
  localparam logic [7:0] KEEP_4NIB = 8'd16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SEND_LO = 2'd1;
  localparam state_t ST_SEND_HI = 2'd2;

  // Returns 0 for any keep value that is not a whole number of nibbles 1..4.
  function automatic logic [2:0] keep_to_nibbles(input logic [7:0] keep);
    case (keep)
      KEEP_1NIB: keep_to_nibbles = 3'd1;
      KEEP_2NIB: keep_to_nibbles = 3'd2;
      KEEP_3NIB: keep_to_nibbles = 3'd3;
      KEEP_4NIB: keep_to_nibbles = 3'd4;
      default:   keep_to_nibbles = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pkt_len_counter.sv
// Saturating per-packet length counter. Accumulates i_add_val per transfer and
// reports the total (plus a saturation flag) one cycle after the last transfer.
module pkt_len_counter #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_add_en,
  input  logic [1:0]       i_add_val,
  input  logic             i_last,
  output logic             o_done,
  output logic [LEN_W-1:0] o_len,
  output logic             o_sat
);

  localparam logic [LEN_W:0] MAX_COUNT = {1'b0, {LEN_W{1'b1}}};

  logic [LEN_W-1:0] r_count;
  logic             r_sat;
  logic             r_done;
  logic [LEN_W-1:0] r_len;
  logic             r_sat_out;

  logic [LEN_W:0]   w_sum;
  logic             w_ovf;
  logic [LEN_W-1:0] w_next;

  assign w_sum  = {1'b0, r_count} + (LEN_W+1)'(i_add_val);
  assign w_ovf  = (w_sum > MAX_COUNT);
  assign w_next = w_ovf ? {LEN_W{1'b1}} : w_sum[LEN_W-1:0];

  // NOTE: every register below uses non-blocking assignment so all flops
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_sat     <= 1'b0;
      r_done    <= 1'b0;
      r_len     <= '0;
      r_sat_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_add_en) begin
        if (i_last) begin
          // Report and clear on the same edge; the next packet starts from 0.
          r_done    <= 1'b1;
          r_len     <= w_next;
          r_sat_out <= r_sat | w_ovf;
          r_count   <= '0;
          r_sat     <= 1'b0;
        end else begin
          r_count <= w_next;
          r_sat   <= r_sat | w_ovf;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_len  = r_len;
  assign o_sat  = r_sat_out;

endmodule

// File: rtl/nibble_byte_downsizer.sv
// Converts the 16-bit packed nibble stream into an 8-bit byte stream with
// byte-level keep/last, drops illegal-keep beats and reports packet lengths.
module nibble_byte_downsizer
  import nibble_stream_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      s_data,
  input  logic [7:0]       s_keep,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic [7:0]       m_keep,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_nibbles,
  output logic             pkt_sat,
  output logic             keep_err
);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_hr_data;
  logic [2:0]  r_hr_n;
  logic        r_hr_last;
  logic        r_keep_err;

  logic [2:0]  w_s_nibbles;
  logic        w_final_byte;
  logic        w_accept;
  logic        w_load;
  logic        w_xfer;
  logic [1:0]  w_add_val;

  assign w_s_nibbles  = keep_to_nibbles(s_keep);
  // The held beat can be replaced only while its last byte is leaving.
  assign w_final_byte = (r_state == ST_SEND_HI) ||
                        ((r_state == ST_SEND_LO) && (r_hr_n <= 3'd2));
  assign s_ready      = (r_state == ST_IDLE) || (m_ready && w_final_byte);
  assign w_accept     = s_valid && s_ready;
  assign w_load       = w_accept && (w_s_nibbles != 3'd0);
  assign m_valid      = (r_state != ST_IDLE);
  assign w_xfer       = m_valid && m_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) w_state_next = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (m_ready) begin
          if (r_hr_n > 3'd2)  w_state_next = ST_SEND_HI;
          else if (w_load)    w_state_next = ST_SEND_LO;
          else                w_state_next = ST_IDLE;
        end
      end
      ST_SEND_HI: begin
        if (m_ready) w_state_next = w_load ? ST_SEND_LO : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred
  // for the IDLE state or unused encodings.
  always_comb begin
    m_data = 8'h00;
    m_keep = 8'h00;
    m_last = 1'b0;
    case (r_state)
      ST_SEND_LO: begin
        m_data = {(r_hr_n >= 3'd2) ? r_hr_data[7:4] : 4'h0, r_hr_data[3:0]};
        m_keep = (r_hr_n >= 3'd2) ? KEEP_2NIB : KEEP_1NIB;
        m_last = r_hr_last && (r_hr_n <= 3'd2);
      end
      ST_SEND_HI: begin
        m_data = {(r_hr_n == 3'd4) ? r_hr_data[15:12] : 4'h0, r_hr_data[11:8]};
        m_keep = (r_hr_n == 3'd4) ? KEEP_2NIB : KEEP_1NIB;
        m_last = r_hr_last;
      end
      default: ;
    endcase
  end

  // NOTE: the holding register is reset with the FSM so a reset mid-packet
  // leaves no stale beat that could surface on m_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_hr_data  <= '0;
      r_hr_n     <= '0;
      r_hr_last  <= 1'b0;
      r_keep_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_keep_err <= w_accept && (w_s_nibbles == 3'd0);
      if (w_load) begin
        r_hr_data <= s_data;
        r_hr_n    <= w_s_nibbles;
        r_hr_last <= s_last;
      end
    end
  end

  assign keep_err  = r_keep_err;
  assign w_add_val = (m_keep == KEEP_2NIB) ? 2'd2 : 2'd1;

  pkt_len_counter #(
    .LEN_W (LEN_W)
  ) u_len (
    .clk       (clk),
    .rst_n     (rst),
    .i_add_en  (w_xfer),
    .i_add_val (w_add_val),
    .i_last    (m_last),
    .o_done    (pkt_done),
    .o_len     (pkt_nibbles),
    .o_sat     (pkt_sat)
  );

endmodule

// File: tb/tb_nibble_byte_downsizer.sv
// Randomised self-checking bench: a queue-based model expands accepted beats
// into expected bytes and packet lengths; a LEN_W=4 copy exercises saturation.
module tb_nibble_byte_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic [7:0]  s_keep;
  logic        s_valid, s_last, m_ready;

  logic        s_ready, m_valid, m_last, pkt_done, pkt_sat, keep_err;
  logic [7:0]  m_data, m_keep;
  logic [11:0] pkt_nibbles;

  logic        s_ready4, m_valid4, m_last4, pkt_done4, pkt_sat4, keep_err4;
  logic [7:0]  m_data4, m_keep4;
  logic [3:0]  pkt_nibbles4;

  always #5 clk = ~clk;

  nibble_byte_downsizer u_dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .pkt_done(pkt_done), .pkt_nibbles(pkt_nibbles), .pkt_sat(pkt_sat), .keep_err(keep_err)
  );

  nibble_byte_downsizer #(.LEN_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready4),
    .m_data(m_data4), .m_keep(m_keep4), .m_valid(m_valid4), .m_last(m_last4), .m_ready(m_ready),
    .pkt_done(pkt_done4), .pkt_nibbles(pkt_nibbles4), .pkt_sat(pkt_sat4), .keep_err(keep_err4)
  );

  typedef struct {
    logic [15:0] data;
    logic [7:0]  keep;
    bit          last;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] keep;
    bit         last;
    bit         beat_end;
  } byte_t;

  beat_t bq[$];
  byte_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit holding = 0;
  int acc = 0;
  bit exp_kerr = 0;
  bit exp_done = 0;
  int hold_len12 = 0;
  int hold_len4 = 0;
  bit exp_sat12 = 0;
  bit exp_sat4 = 0;
  int obs_len = 0;
  int obs_len4 = 0;
  bit obs_sat4 = 0;
  int done_seen = 0;
  int kerr_seen = 0;

  function automatic int nib_count(input logic [7:0] k);
    if (k != 0 && (k % 4) == 0 && k <= 16) return int'(k) / 4;
    return 0;
  endfunction

  function automatic void expand_beat(input beat_t b);
    int n;
    int nbytes;
    n = nib_count(b.keep);
    nbytes = (n + 1) / 2;
    for (int i = 0; i < nbytes; i++) begin
      byte_t e;
      logic [3:0] lo, hi;
      lo = b.data[8*i +: 4];
      hi = (2*i + 1 < n) ? b.data[8*i+4 +: 4] : 4'h0;
      e.data = {hi, lo};
      e.keep = (2*i + 1 < n) ? 8'd8 : 8'd4;
      e.last = b.last && (i == nbytes - 1);
      e.beat_end = (i == nbytes - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic push_beat(input logic [15:0] d, input logic [7:0] k, input bit l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    bq.push_back(b);
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later,
  // advance the model, then wait for the next falling edge.
  task automatic step(input int vpct, input int rpct);
    bit mdl_ready, xfer, acc_now;
    bit rpat[4];
    byte_t f;
    beat_t b;
    int len;
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    if (!holding && bq.size() > 0 && $urandom_range(99) < vpct) holding = 1;
    if (holding) begin
      s_valid = 1'b1;
      s_data  = bq[0].data;
      s_keep  = bq[0].keep;
      s_last  = bq[0].last;
    end else begin
      s_valid = 1'b0;
      s_data  = 16'($urandom);
      s_keep  = 8'($urandom);
      s_last  = 1'($urandom);
    end
    if (rpct < 0) m_ready = rpat[cyc % 4];
    else          m_ready = ($urandom_range(99) < rpct);
    #1;

    mdl_ready = (exp_q.size() == 0) || (m_ready && exp_q[0].beat_end);

    checks++;
    if (keep_err !== exp_kerr) begin
      errors++;
      $display("FAIL keep_err cyc=%0d got=%b exp=%b", cyc, keep_err, exp_kerr);
    end
    checks++;
    if (pkt_done !== exp_done) begin
      errors++;
      $display("FAIL pkt_done cyc=%0d got=%b exp=%b", cyc, pkt_done, exp_done);
    end
    checks++;
    if (pkt_nibbles !== 12'(hold_len12) || pkt_nibbles4 !== 4'(hold_len4)) begin
      errors++;
      $display("FAIL pkt_nibbles cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc,
               pkt_nibbles, pkt_nibbles4, hold_len12, hold_len4);
    end
    if (exp_done) begin
      checks++;
      if (pkt_sat !== exp_sat12 || pkt_sat4 !== exp_sat4) begin
        errors++;
        $display("FAIL pkt_sat cyc=%0d got=%b/%b exp=%b/%b", cyc, pkt_sat, pkt_sat4,
                 exp_sat12, exp_sat4);
      end
    end
    checks++;
    if (m_valid !== (exp_q.size() > 0)) begin
      errors++;
      $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, exp_q.size() > 0);
    end
    if (exp_q.size() > 0) begin
      checks++;
      if (m_data !== exp_q[0].data || m_keep !== exp_q[0].keep || m_last !== exp_q[0].last) begin
        errors++;
        $display("FAIL m_byte cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc, m_data, m_keep,
                 m_last, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
      end
    end
    checks++;
    if (s_ready !== mdl_ready) begin
      errors++;
      $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, mdl_ready);
    end

    if (pkt_done) begin
      done_seen++;
      obs_len  = int'(pkt_nibbles);
      obs_len4 = int'(pkt_nibbles4);
      obs_sat4 = pkt_sat4;
    end
    if (keep_err) kerr_seen++;

    exp_done = 0;
    exp_kerr = 0;
    xfer = (exp_q.size() > 0) && m_ready;
    acc_now = holding && mdl_ready;
    if (xfer) begin
      f = exp_q.pop_front();
      acc += (f.keep == 8'd8) ? 2 : 1;
      if (f.last) begin
        len = acc;
        exp_done = 1;
        hold_len12 = (len > 4095) ? 4095 : len;
        hold_len4  = (len > 15) ? 15 : len;
        exp_sat12  = (len > 4095);
        exp_sat4   = (len > 15);
        acc = 0;
      end
    end
    if (acc_now) begin
      b = bq.pop_front();
      holding = 0;
      if (nib_count(b.keep) == 0) exp_kerr = 1;
      else expand_beat(b);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_traffic(input int vpct, input int rpct, input int budget, output int steps);
    steps = 0;
    while ((bq.size() > 0 || exp_q.size() > 0 || exp_done || exp_kerr) && steps < budget) begin
      step(vpct, rpct);
      steps++;
    end
    checks++;
    if (steps >= budget) begin
      errors++;
      $display("FAIL traffic_timeout got=%0d cycles exp<%0d beats_left=%0d", steps, budget, bq.size());
      bq.delete();
      holding = 0;
    end
    step(0, 100);
  endtask

  task automatic expect_pkt(input string name, input int done_before, input int len);
    checks++;
    if (done_seen - done_before !== 1 || obs_len !== len) begin
      errors++;
      $display("FAIL %s got=%0d pkts len %0d exp=1 pkts len %0d", name,
               done_seen - done_before, obs_len, len);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({m_data, m_keep, m_valid, m_last, pkt_done, pkt_nibbles, pkt_sat, keep_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%h/%b/%b/%b/%h/%b/%b exp=all 0", m_data, m_keep,
               m_valid, m_last, pkt_done, pkt_nibbles, pkt_sat, keep_err);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready got=%b exp=1", s_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    int d0, n;
    d0 = done_seen;
    push_beat(16'hABCD, 8'd16, 1);
    run_traffic(100, 100, 50, n);
    expect_pkt("single_beat_len", d0, 4);
  endtask

  task automatic test_partial_beat();
    int d0, n;
    d0 = done_seen;
    push_beat(16'h1234, 8'd16, 0);
    push_beat(16'h0567, 8'd12, 1);
    run_traffic(100, 100, 50, n);
    expect_pkt("partial_beat_len", d0, 7);
  endtask

  task automatic test_short_last();
    int d0, n;
    d0 = done_seen;
    push_beat(16'hFFF9, 8'd4, 1);
    run_traffic(100, 100, 50, n);
    expect_pkt("short_last_len", d0, 1);
  endtask

  task automatic test_stall();
    int d0, n;
    d0 = done_seen;
    for (int i = 0; i < 3; i++) push_beat(16'($urandom), 8'd16, i == 2);
    run_traffic(100, -1, 100, n);
    expect_pkt("stall_len", d0, 12);
  endtask

  task automatic test_illegal_keep();
    int d0, k0, n;
    d0 = done_seen;
    k0 = kerr_seen;
    push_beat(16'h1111, 8'd16, 0);
    push_beat(16'h2222, 8'd6, 0);
    push_beat(16'h3333, 8'd0, 1);
    push_beat(16'h4444, 8'd8, 1);
    run_traffic(100, 100, 50, n);
    expect_pkt("illegal_keep_len", d0, 6);
    checks++;
    if (kerr_seen - k0 !== 2) begin
      errors++;
      $display("FAIL keep_err_count got=%0d exp=2", kerr_seen - k0);
    end
  endtask

  task automatic test_back_to_back();
    int d0, n;
    d0 = done_seen;
    for (int i = 0; i < 4; i++) push_beat(16'($urandom), 8'd16, i == 3);
    run_traffic(100, 100, 50, n);
    expect_pkt("b2b_len", d0, 16);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL b2b_cycles got=%0d exp=10", n);
    end
  endtask

  task automatic test_reset_mid_packet();
    int d0, n;
    push_beat(16'h1234, 8'd16, 0);
    step(100, 100);
    step(100, 100);
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({m_data, m_keep, m_valid, m_last, pkt_done, pkt_nibbles, pkt_sat, keep_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h/%h/%b/%b/%b/%h/%b/%b exp=all 0", m_data, m_keep,
               m_valid, m_last, pkt_done, pkt_nibbles, pkt_sat, keep_err);
    end
    bq.delete();
    exp_q.delete();
    holding = 0;
    acc = 0;
    exp_done = 0;
    exp_kerr = 0;
    hold_len12 = 0;
    hold_len4 = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    d0 = done_seen;
    push_beat(16'h5555, 8'd8, 1);
    run_traffic(100, 100, 50, n);
    expect_pkt("post_reset_len", d0, 2);
  endtask

  task automatic test_saturation();
    int d0, n;
    d0 = done_seen;
    for (int i = 0; i < 5; i++) push_beat(16'($urandom), 8'd16, i == 4);
    run_traffic(80, 80, 200, n);
    expect_pkt("sat_len12", d0, 20);
    checks++;
    if (obs_len4 !== 15 || obs_sat4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_len4 got=%0d sat=%b exp=15 sat=1", obs_len4, obs_sat4);
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] bad_keeps[5];
    bad_keeps = '{8'd0, 8'd6, 8'd3, 8'd20, 8'd255};
    for (int i = 0; i < 300; i++) begin
      logic [7:0] k;
      if ($urandom_range(9) == 0) k = bad_keeps[$urandom_range(4)];
      else k = 8'(4 * $urandom_range(1, 4));
      push_beat(16'($urandom), k, (i == 299) || ($urandom_range(3) == 0));
    end
    run_traffic(70, 70, 5000, n);
  endtask

  initial begin
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_keep = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_partial_beat();
    test_short_last();
    test_stall();
    test_illegal_keep();
    test_back_to_back();
    test_reset_mid_packet();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_byte_downsizer.md
Name: nibble_byte_downsizer

Overview:
- Downstream stage of the nibble packer. Consumes its 16-bit packed nibble stream (keep = count of valid bits: 4/8/12/16) and re-emits it as an 8-bit byte stream with byte-level keep and last.
- Gives downstream byte-wide consumers a correct valid/ready handshake.
- Reports the nibble length of every completed packet.

Parameters:
- LEN_W, 12, width of the per-packet nibble-length counter and report.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  16  packed nibbles; nibble 0 in [3:0].
- s_keep  in  8  valid-bit count of the beat. Legal values: 4, 8, 12, 16.
- s_valid  in  1  upstream beat valid.
- s_last  in  1  final beat of packet.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- m_data  out  8  output byte; unused nibble forced to 0.
- m_keep  out  8  4 (low nibble only) or 8 (both nibbles).
- m_valid  out  1  output byte valid.
- m_last  out  1  final byte of packet.
- m_ready  in  1  downstream ready.
- pkt_done  out  1  one-cycle pulse when a packet completes.
- pkt_nibbles  out  LEN_W  nibble count of the completed packet; valid with pkt_done.
- pkt_sat  out  1  set with pkt_done if the count saturated.
- keep_err  out  1  one-cycle pulse when an illegal-keep beat is dropped.

Behaviour:
- Reset (rst low, async): state IDLE, holding register cleared, counter 0. All outputs 0 (m_data, m_keep, m_valid, m_last, pkt_done, pkt_nibbles, pkt_sat, keep_err). s_ready = 1 once reset is released.
- Reset mid-packet discards the held beat and the partial count; no pkt_done is produced.
- Holding register: hr_data[15:0], hr_n (1..4, nibble count = s_keep/4), hr_last. Loaded on every accepted legal beat.
- States: IDLE, SEND_LO, SEND_HI.
- m_valid = (state != IDLE).
- m_data, m_keep and m_last are decoded from registers only. There is no combinational path from s_* to m_*.
- SEND_LO byte:
  - m_data = {hr_n>=2 ? hr_data[7:4] : 0, hr_data[3:0]}.
  - m_keep = (hr_n>=2) ? 8 : 4.
  - m_last = hr_last && hr_n<=2.
- SEND_HI byte:
  - m_data = {hr_n==4 ? hr_data[15:12] : 0, hr_data[11:8]}.
  - m_keep = (hr_n==4) ? 8 : 4.
  - m_last = hr_last.
- s_ready = IDLE || (m_ready && current byte is the beat's final byte). The final byte is SEND_HI, or SEND_LO with hr_n<=2. The only combinational input-to-output path is m_ready -> s_ready.
- Transitions:
  - IDLE: on a legal accept -> SEND_LO.
  - SEND_LO && m_ready: if hr_n>2 -> SEND_HI; else if a legal accept occurs the same cycle -> SEND_LO (reload); else -> IDLE.
  - SEND_HI && m_ready: legal accept -> SEND_LO; else -> IDLE.
  - No m_ready: hold state, m_data, m_keep and m_last stable (AXI-stream rule).
- Latency: accepted beat -> first byte on m_* the next cycle.
- Throughput: 1 byte/cycle. Back-to-back full beats sustain one 16-bit beat per 2 cycles with no bubbles.
- Illegal keep (0 or any value not 4/8/12/16):
  - Beat is still accepted (s_ready honoured), then discarded.
  - keep_err pulses the next cycle.
  - s_last on that beat is ignored: the packet continues.
- Short beat (keep<16) without s_last is legal; emitted as-is.
- Length counter:
  - Adds 1 or 2 for each byte transferred (m_valid && m_ready), per m_keep.
  - Saturates at 2^LEN_W-1 and records saturation.
  - On the transferred byte with m_last: next cycle pkt_done=1 with pkt_nibbles = final total and pkt_sat = saturation flag; counter and flag cleared the same edge.
  - pkt_nibbles holds its value until the next pkt_done.
- Simultaneous events: a reload in SEND_LO/SEND_HI and a final-byte transfer in the same cycle are both honoured. A counter clear and the new packet's first byte in the same cycle: the clear applies first, then the new byte is added.

Decomposition:
- Shared package nibble_stream_pkg:
  - KEEP_1NIB=4, KEEP_2NIB=8, KEEP_3NIB=12, KEEP_4NIB=16.
  - State encoding typedef (IDLE/SEND_LO/SEND_HI).
  - Function keep_to_nibbles returning 0 for illegal values.
- One sub-module: pkt_len_counter (saturating counter + done/report register), reused by other stream stages.

Test Plan:
- Single beat s_data=16'hABCD, keep=16, last=1, m_ready=1 -> bytes 8'hCD(keep 8,last 0), 8'hAB(keep 8,last 1); pkt_done with pkt_nibbles=4 one cycle after the second byte.
- Beats 16'h1234 keep16, then 16'h0567 keep12 last -> bytes 34,12,67,05(keep 4,last 1); s_ready low during the first byte of each beat; pkt_nibbles=7.
- Last beat keep=4, s_data=16'hFFF9 -> single byte 8'h09, m_keep=4, m_last=1; pkt_nibbles counts 1 for that beat.
- m_ready toggling 1-0-0-1 while streaming 3 full beats -> m_data stable while stalled, no byte lost or duplicated, s_ready never high while a non-final byte is held.
- Beat with keep=6 mid-packet -> dropped, keep_err pulse, m_* unaffected, pkt_nibbles excludes it; keep=0 with last=1 does not end the packet.
- Assert rst while in SEND_HI -> all outputs 0 immediately; the next packet reports only its own length; with LEN_W=4, a 20-nibble packet gives pkt_nibbles=15, pkt_sat=1.
